// File: rtl/mfp_sys_sw2led.sv
// mfp_sys_sw2led: switch-to-LED smoke-test system with the mfp_sys pin-out
// A hardwired bus-master FSM loops: read switch register, write LED register.
// Ports:
//   SI_ClkIn, SI_Reset (sync, active-high); SI_ColdReset_N, EJ_*, UART_RX ignored
//   EJ_TDO constant 0; IO_Switch/IO_PB inputs, IO_LED register output
//   HADDR/HRDATA/HWDATA/HWRITE/HSIZE: exported internal bus for observation
// Option: define MFP_SYS_PB_EN to add the pushbutton read (inverts LED data when any PB is pressed).
module mfp_sys_sw2led #(
    parameter int N_SW  = 16,
    parameter int N_LED = 16
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset,
    input  logic             SI_ColdReset_N,
    input  logic             EJ_TRST_N_probe,
    input  logic             EJ_TDI,
    input  logic             EJ_TMS,
    input  logic             EJ_TCK,
    input  logic             EJ_DINT,
    output logic             EJ_TDO,
    input  logic             UART_RX,
    input  logic [N_SW-1:0]  IO_Switch,
    input  logic [4:0]       IO_PB,
    output logic [N_LED-1:0] IO_LED,
    output logic [31:0]      HADDR,
    output logic [31:0]      HRDATA,
    output logic [31:0]      HWDATA,
    output logic             HWRITE,
    output logic [2:0]       HSIZE
);
    localparam logic [31:0] A_LED = 32'hBF80_0000;
    localparam logic [31:0] A_SW  = 32'hBF80_0008;
    localparam logic [31:0] A_PB  = 32'hBF80_000C;
    typedef enum logic [2:0] {RD_SW_A, RD_SW_D, RD_PB_A, RD_PB_D, WR_LED_A, WR_LED_D} state_t;
    state_t state;
    logic [N_SW-1:0] sw_q;
    logic [31:0] data_q;
`ifdef MFP_SYS_PB_EN
    logic [4:0] pb_q;
    logic unused_ok;
    assign unused_ok = &{1'b0, SI_ColdReset_N, EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT, UART_RX};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, SI_ColdReset_N, EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT, UART_RX, IO_PB};
`endif
    assign EJ_TDO = 1'b0;
    assign HSIZE  = 3'b010;
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state  <= RD_SW_A;
            IO_LED <= '0;
            data_q <= '0;
            sw_q   <= '0;
`ifdef MFP_SYS_PB_EN
            pb_q   <= '0;
`endif
        end else begin
            sw_q <= IO_Switch;
`ifdef MFP_SYS_PB_EN
            pb_q <= IO_PB;
`endif
            case (state)
                RD_SW_A: state <= RD_SW_D;
                RD_SW_D: begin
                    data_q <= 32'(sw_q);
`ifdef MFP_SYS_PB_EN
                    state  <= RD_PB_A;
`else
                    state  <= WR_LED_A;
`endif
                end
`ifdef MFP_SYS_PB_EN
                RD_PB_A: state <= RD_PB_D;
                RD_PB_D: begin
                    if (pb_q != '0) data_q[N_SW-1:0] <= ~data_q[N_SW-1:0];
                    state <= WR_LED_A;
                end
`endif
                WR_LED_A: state <= WR_LED_D;
                WR_LED_D: begin
                    IO_LED <= HWDATA[N_LED-1:0];
                    state  <= RD_SW_A;
                end
                default: state <= RD_SW_A;
            endcase
        end
    end
    // Reset forces the idle bus view immediately, not just after the reset edge.
    always_comb begin
        HADDR  = (state == WR_LED_A || state == WR_LED_D) ? A_LED :
                 (state == RD_PB_A || state == RD_PB_D) ? A_PB : A_SW;
        HWRITE = state == WR_LED_A || state == WR_LED_D;
        HRDATA = state == RD_SW_D ? 32'(sw_q) : '0;
`ifdef MFP_SYS_PB_EN
        HRDATA = (state == RD_PB_A || state == RD_PB_D) ? {27'b0, pb_q} : HRDATA;
`endif
        HWDATA = state == WR_LED_D ? data_q : '0;
        HADDR  = SI_Reset ? A_SW : HADDR;
        HWRITE = !SI_Reset && HWRITE;
        HRDATA = SI_Reset ? '0 : HRDATA;
        HWDATA = SI_Reset ? '0 : HWDATA;
    end
endmodule

// File: tb/tb_mfp_sys_sw2led.sv
// tb_mfp_sys_sw2led: scoreboard bench for the switch-to-LED system (default build)
module tb_mfp_sys_sw2led;
    localparam logic [31:0] A_LED = 32'hBF80_0000;
    localparam logic [31:0] A_SW  = 32'hBF80_0008;
    logic clk = 1'b0, rst = 1'b1;
    logic cold = 1'b1, trst = 1'b1, tdi = 1'b0, tms = 1'b0, tck = 1'b0, dint = 1'b0, urx = 1'b1;
    logic tdo, hwrite;
    logic [15:0] sw = 16'hABCD, led;
    logic [4:0] pb = 5'd0;
    logic [31:0] haddr, hrdata, hwdata;
    logic [2:0] hsize;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    int p = 0;
    logic [15:0] sw_m = '0, data_m = '0, led_m = '0;
    always #5 clk = ~clk;
    mfp_sys_sw2led dut (
        .SI_ClkIn(clk), .SI_Reset(rst), .SI_ColdReset_N(cold),
        .EJ_TRST_N_probe(trst), .EJ_TDI(tdi), .EJ_TMS(tms), .EJ_TCK(tck), .EJ_DINT(dint),
        .EJ_TDO(tdo), .UART_RX(urx), .IO_Switch(sw), .IO_PB(pb), .IO_LED(led),
        .HADDR(haddr), .HRDATA(hrdata), .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Reference model: phase p counts RD_SW_A, RD_SW_D, WR_LED_A, WR_LED_D.
    always @(posedge clk) begin
        sw_m <= rst ? 16'h0 : sw;
        if (rst) begin
            p <= 0;
            data_m <= '0;
            led_m <= '0;
        end else begin
            p <= (p + 1) % 4;
            if (p == 1) data_m <= sw_m;
            if (p == 3) led_m <= data_m;
        end
    end
    // Monitor: checks the bus trace every cycle and pops the scoreboard on each LED write.
    always @(negedge clk) begin
        chk("hsize", 32'(hsize), 32'h2);
        chk("ej_tdo", 32'(tdo), 32'h0);
        chk("io_led", 32'(led), 32'(led_m));
        if (rst) begin
            chk("rst_haddr", haddr, A_SW);
            chk("rst_hwrite", 32'(hwrite), 32'h0);
            chk("rst_hrdata", hrdata, 32'h0);
            chk("rst_hwdata", hwdata, 32'h0);
        end else begin
            chk("haddr", haddr, p >= 2 ? A_LED : A_SW);
            chk("hwrite", 32'(hwrite), 32'(p >= 2));
            chk("hrdata", hrdata, p == 1 ? {16'h0, sw_m} : 32'h0);
            chk("hwdata", hwdata, p == 3 ? {16'h0, data_m} : 32'h0);
            if (p == 3 && exp_q.size() > 0) chk("sb_hwdata", hwdata, exp_q.pop_front());
        end
    end
    task automatic apply(input logic [15:0] v, input bit noisy);
        @(posedge clk); #2;
        sw = v;
        for (int i = 0; i < 100; i++) begin
            if (noisy) {cold, trst, tdi, tms, tck, dint, urx} = 7'($urandom);
            @(negedge clk);
            if (i == 8) begin
                chk("led_latency", 32'(led), 32'(v));
                exp_q.push_back({16'h0, v});
            end
            @(posedge clk); #2;
        end
    endtask
    initial begin
        repeat (100) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        apply(16'hABCD, 1'b0);
        apply(16'h1234, 1'b0);
        apply(16'h0011, 1'b0);
        apply(16'hFFFF, 1'b0);
        apply(16'hAAAA, 1'b0);
        for (int i = 0; i < 4 && p != 3; i++) begin
            @(posedge clk); #2;
        end
        chk("find_wr_led_d", 32'(p), 32'd3);
        chk("led_before_rst", 32'(led), 32'hAAAA);
        rst = 1'b1;
        sw = 16'h5555;
        @(posedge clk); #2;
        chk("led_cleared", 32'(led), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        apply(16'h5555, 1'b0);
        apply(16'h0F0F, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
